// File: rtl/slow_p2s_pkg.sv
// Shared definitions for the slow parallel-to-serial transmitter.
package slow_p2s_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width of the bit counter that indexes a word of the given width.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/slow_p2s_tx_if.sv
// Word-side handshake and serial-side outputs of the transmitter.
interface slow_p2s_tx_if
  import slow_p2s_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] DATA_IN;
  logic             VALID_IN;
  logic             READY_OUT;
  logic             SER_OUT;
  logic             SER_VALID;
  logic             SER_SYNC;

  // Producer of words and consumer of the serial stream.
  modport master (
    output DATA_IN, VALID_IN,
    input  READY_OUT, SER_OUT, SER_VALID, SER_SYNC
  );

  // The transmitter itself.
  modport slave (
    input  DATA_IN, VALID_IN,
    output READY_OUT, SER_OUT, SER_VALID, SER_SYNC
  );

endinterface

// File: rtl/slow_p2s_tx_rise_detect.sv
// Rising-edge detector for a slow signal sampled in the CLK domain.
// PULSE is high for one CLK when IN is seen high after being low.
module rise_detect (
  input  logic CLK,
  input  logic RESET,
  input  logic IN,
  output logic PULSE
);

  logic slow_q;

  // Previous-cycle copy of IN; resets high so a level already high at
  // reset release is not mistaken for a fresh rising edge.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values, independent of block ordering.
    if (RESET) slow_q <= 1'b1;
    else       slow_q <= IN;
  end

  assign PULSE = IN && !slow_q;

endmodule

// File: rtl/slow_p2s_tx.sv
// Parallel-to-serial transmitter: one-word holding buffer feeding an
// MSB-first shifter that advances on each rising edge of CLK_SLOW.
// CLK_SLOW is only a sampled enable; all logic runs on CLK.
module slow_p2s_tx
  import slow_p2s_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
)
(
  input  logic         CLK,
  input  logic         RESET,
  input  logic         CLK_SLOW,
  slow_p2s_tx_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  logic             tick;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic             hold_valid;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] shreg;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_sync;
  logic             accept;
  logic             load;
  logic             shift;

  rise_detect u_rise (
    .CLK   (CLK),
    .RESET (RESET),
    .IN    (CLK_SLOW),
    .PULSE (tick)
  );

  // Decode this cycle's accept / load / shift actions.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    accept = bus.VALID_IN && !hold_valid;
    load   = 1'b0;
    shift  = 1'b0;
    if (tick) begin
      case (state)
        IDLE:    load = hold_valid;
        SHIFT:   if (cnt != '0) shift = 1'b1;
                 else           load  = hold_valid;
        default: ;
      endcase
    end
  end

  // Control FSM: buffer flag, state, bit counter and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      hold_valid <= 1'b0;
      ser_out    <= 1'b0;
      ser_valid  <= 1'b0;
      ser_sync   <= 1'b0;
    end else begin
      // accept needs an empty buffer and load a full one: never both.
      if (accept)    hold_valid <= 1'b1;
      else if (load) hold_valid <= 1'b0;

      if (load) begin
        state     <= SHIFT;
        cnt       <= CW'(WIDTH - 1);
        ser_out   <= hold[WIDTH-1];
        ser_valid <= 1'b1;
        ser_sync  <= 1'b1;
      end else if (shift) begin
        cnt       <= cnt - 1'b1;
        ser_out   <= shreg[WIDTH-2];
        ser_sync  <= 1'b0;
      end else if (tick && state == SHIFT) begin
        // Last bit finished with nothing buffered: end of stream.
        state     <= IDLE;
        ser_out   <= 1'b0;
        ser_valid <= 1'b0;
        ser_sync  <= 1'b0;
      end
    end
  end

  // Data path: holding register and shift register.
  always_ff @(posedge CLK) begin
    // NOTE: data registers are not reset; their contents are only used
    // while the reset-cleared hold_valid / state say they are meaningful.
    if (accept) hold <= bus.DATA_IN;
    if (load)       shreg <= hold;
    else if (shift) shreg <= {shreg[WIDTH-2:0], 1'b0};
  end

  assign bus.READY_OUT = !hold_valid;
  assign bus.SER_OUT   = ser_out;
  assign bus.SER_VALID = ser_valid;
  assign bus.SER_SYNC  = ser_sync;

endmodule
